// File: rtl/keyboard_host_tx.sv
// keyboard_host_tx: PS/2 host-to-device command transmitter.
//
// Sends one command byte to the keyboard. The frame is start, D0..D7 (LSB
// first), odd parity, stop, and then the device's ACK bit is checked. The PS/2
// clock and data lines are driven only through open-drain enables (1 = pull low).
// Bit changes are timed on device falling clock edges. These edges come from
// keyboard_negedge_detector, which samples the synchronized clock line.
//
// Optional feature: define KB_TX_TIMEOUT_EN to abort a transfer whose device
// clocking does not complete within TIMEOUT_CYCLES of clock release. The abort
// reports o_done with o_err. Without the macro the block waits indefinitely.

// Falling-edge detector for the device-generated PS/2 clock.
// The line is 2-FF synchronized and then sampled once every SAMPLE_DIV cycles.
// A fall is reported as a one-cycle pulse when a high sample is followed by a
// low sample, so short glitches between samples are ignored.
module keyboard_negedge_detector #(
    parameter int SAMPLE_DIV = 32
) (
    input  logic clk,
    input  logic i_sclr,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [1:0]       sync_r;
    logic [DIV_W-1:0] div_r;
    logic             samp_r;
    logic             fall_r;
    logic             tick_s;

    assign tick_s  = (div_r == DIV_LAST);
    assign o_level = sync_r[1];
    assign o_fall  = fall_r;

    // Two-flop synchronizer; the line idles high, so reset to 1.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], i_line};
        end
    end

    // Sampling divider and high-to-low sample comparison.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            div_r  <= {DIV_W{1'b0}};
            samp_r <= 1'b1;
            fall_r <= 1'b0;
        end else if (tick_s) begin
            div_r  <= {DIV_W{1'b0}};
            samp_r <= sync_r[1];
            fall_r <= samp_r & ~sync_r[1];
        end else begin
            div_r  <= div_r + DIV_ONE;
            fall_r <= 1'b0;
        end
    end
endmodule

// Host transmitter top.
module keyboard_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_ps2_clk_n,
    input  logic       i_ps2_dat_n,
    input  logic       i_wr,
    input  logic [7:0] i_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);
    localparam logic [19:0] INHIBIT_LAST  = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] SETUP_LAST    = 20'(SETUP_CYCLES - 1);
    localparam logic [3:0]  LAST_DATA_IDX = 4'd9;

    // The shared phase/timeout counter is 20 bits wide, so every cycle count must fit.
    generate
        if ((INHIBIT_CYCLES < 1) || (INHIBIT_CYCLES >= 1048576) ||
            (SETUP_CYCLES < 1)   || (SETUP_CYCLES >= 1048576)   ||
            (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= 1048576)) begin : g_bad_params
            $error("keyboard_host_tx: cycle parameters must lie in 1 .. 2^20-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Odd parity bit for a data byte.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t      state_r, state_next;
    logic [19:0] cnt_r, cnt_next;
    logic [8:0]  sr_r, sr_next;
    logic [3:0]  bit_idx_r, bit_idx_next;
    logic        nack_r, nack_next;
    logic        clk_oe_r, clk_oe_next;
    logic        dat_oe_r, dat_oe_next;
    logic        busy_r, busy_next;
    logic        done_r, done_next;
    logic        err_r, err_next;
    logic [1:0]  dat_sync_r;

    logic        clk_level_s;
    logic        clk_fall_s;
    logic        dat_level_s;
    logic        timeout_hit_s;
    logic [19:0] cnt_run_s;

    assign dat_level_s  = dat_sync_r[1];
    assign o_ps2_clk_oe = clk_oe_r;
    assign o_ps2_dat_oe = dat_oe_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_err        = err_r;

    keyboard_negedge_detector #(
        .SAMPLE_DIV (32)
    ) u_clk_edge (
        .clk     (clk),
        .i_sclr  (i_sclr),
        .i_line  (i_ps2_clk_n),
        .o_level (clk_level_s),
        .o_fall  (clk_fall_s)
    );

`ifdef KB_TX_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
    // After clock release the phase counter measures elapsed time to ACK completion.
    assign timeout_hit_s = (cnt_r == TIMEOUT_LAST);
    assign cnt_run_s     = cnt_r + 20'd1;
`else
    // No timeout: the counter stays parked once the clock is released.
    assign timeout_hit_s = 1'b0;
    assign cnt_run_s     = cnt_r;
`endif

    // Two-flop synchronizer for the data line; it idles high.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            dat_sync_r <= 2'b11;
        end else begin
            dat_sync_r <= {dat_sync_r[0], i_ps2_dat_n};
        end
    end

    // Next-state and next-output logic; outputs are registered from *_next.
    always_comb begin
        state_next   = state_r;
        cnt_next     = cnt_r;
        sr_next      = sr_r;
        bit_idx_next = bit_idx_r;
        nack_next    = nack_r;
        clk_oe_next  = 1'b0;
        dat_oe_next  = 1'b0;
        busy_next    = 1'b1;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // busy_r is still high in the o_done cycle, so a strobe there is dropped.
                if (i_wr && !busy_r) begin
                    sr_next      = {odd_parity(i_dat), i_dat};
                    cnt_next     = 20'd0;
                    bit_idx_next = 4'd0;
                    nack_next    = 1'b0;
                    clk_oe_next  = 1'b1;
                    state_next   = ST_INHIBIT;
                end else begin
                    busy_next = 1'b0;
                end
            end

            ST_INHIBIT: begin
                clk_oe_next = 1'b1;
                if (cnt_r == INHIBIT_LAST) begin
                    cnt_next    = 20'd0;
                    dat_oe_next = 1'b1;
                    state_next  = ST_REQ;
                end else begin
                    cnt_next = cnt_r + 20'd1;
                end
            end

            ST_REQ: begin
                // The start bit (data low) stays driven after the clock is released.
                dat_oe_next = 1'b1;
                if (cnt_r == SETUP_LAST) begin
                    cnt_next     = 20'd0;
                    bit_idx_next = 4'd0;
                    state_next   = ST_SHIFT;
                end else begin
                    clk_oe_next = 1'b1;
                    cnt_next    = cnt_r + 20'd1;
                end
            end

            ST_SHIFT: begin
                cnt_next = cnt_run_s;
                if (timeout_hit_s) begin
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (clk_fall_s) begin
                    if (bit_idx_r == LAST_DATA_IDX) begin
                        // Tenth edge: release data for the stop bit.
                        dat_oe_next = 1'b0;
                        state_next  = ST_ACK;
                    end else begin
                        dat_oe_next  = ~sr_r[0];
                        sr_next      = {1'b1, sr_r[8:1]};
                        bit_idx_next = bit_idx_r + 4'd1;
                    end
                end else begin
                    dat_oe_next = dat_oe_r;
                end
            end

            ST_ACK: begin
                cnt_next = cnt_run_s;
                if (timeout_hit_s) begin
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (clk_fall_s) begin
                    nack_next  = dat_level_s;
                    state_next = ST_WAIT_IDLE;
                end else begin
                    nack_next = nack_r;
                end
            end

            ST_WAIT_IDLE: begin
                cnt_next = cnt_run_s;
                if (timeout_hit_s) begin
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (clk_level_s && dat_level_s) begin
                    done_next  = 1'b1;
                    err_next   = nack_r;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT_IDLE;
                end
            end

            default: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 20'd0;
            sr_r      <= 9'd0;
            bit_idx_r <= 4'd0;
            nack_r    <= 1'b0;
            clk_oe_r  <= 1'b0;
            dat_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_next;
            cnt_r     <= cnt_next;
            sr_r      <= sr_next;
            bit_idx_r <= bit_idx_next;
            nack_r    <= nack_next;
            clk_oe_r  <= clk_oe_next;
            dat_oe_r  <= dat_oe_next;
            busy_r    <= busy_next;
            done_r    <= done_next;
            err_r     <= err_next;
        end
    end
endmodule

// File: tb/tb_keyboard_host_tx.sv
// tb_keyboard_host_tx: directed and randomized checks of the PS/2 host
// transmitter against a simple open-drain keyboard device model.
module tb_keyboard_host_tx;
    localparam int INH   = 200;
    localparam int SETUP = 16;
    localparam int TO    = 20000;
    localparam int HALF  = 500;

    logic       clk = 1'b0;
    logic       i_sclr;
    logic       i_wr;
    logic [7:0] i_dat;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       o_ps2_clk_oe;
    logic       o_ps2_dat_oe;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int     n_checks   = 0;
    int     n_fail     = 0;
    longint cyc        = 0;
    int     done_cnt   = 0;
    logic   last_err   = 1'b0;
    longint rel_time   = 0;
    logic   clk_oe_prev = 1'b0;
    logic   mon_clr    = 1'b0;
    int     clk_oe_hi  = 0;
    int     both_hi    = 0;
    int     first_both = -1;

    always #10 clk = ~clk;

    // Wired-AND open-drain lines: low if either side pulls.
    assign ps2_clk = ~(o_ps2_clk_oe | dev_clk_low);
    assign ps2_dat = ~(o_ps2_dat_oe | dev_dat_low);

    keyboard_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .i_sclr       (i_sclr),
        .i_ps2_clk_n  (ps2_clk),
        .i_ps2_dat_n  (ps2_dat),
        .i_wr         (i_wr),
        .i_dat        (i_dat),
        .o_ps2_clk_oe (o_ps2_clk_oe),
        .o_ps2_dat_oe (o_ps2_dat_oe),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: done pulses, clock release time, request-phase lengths.
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            last_err <= o_err;
        end
        if (clk_oe_prev === 1'b1 && o_ps2_clk_oe === 1'b0) rel_time <= cyc;
        clk_oe_prev <= o_ps2_clk_oe;
        if (mon_clr) begin
            clk_oe_hi  <= 0;
            both_hi    <= 0;
            first_both <= -1;
        end else if (o_ps2_clk_oe === 1'b1) begin
            clk_oe_hi <= clk_oe_hi + 1;
            if (o_ps2_dat_oe === 1'b1) begin
                both_hi <= both_hi + 1;
                if (first_both < 0) first_both <= clk_oe_hi;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: [0]=start 0, [8:1]=data LSB first, [9]=odd parity, [10]=stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d, 1'b0};
    endfunction

    task automatic clear_mon();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic start_wr(input logic [7:0] d);
        @(negedge clk);
        i_dat = d;
        i_wr  = 1'b1;
        @(negedge clk);
        i_wr  = 1'b0;
    endtask

    // Keyboard model: captures the start bit at clock release, produces n_edges
    // clock pulses sampling data on each rising edge, and on a full frame
    // answers the ACK slot (data low = ACK, left high = NACK).
    task automatic dev_xfer(input int n_edges, input bit nack, output logic [10:0] cap);
        int t;
        cap = 11'h7FF;
        t = 0;
        while (o_ps2_clk_oe !== 1'b1 && t < 30000) begin @(negedge clk); t++; end
        chk("dev_req_seen", {31'd0, o_ps2_clk_oe}, 32'd1);
        t = 0;
        while (ps2_clk !== 1'b1 && t < 30000) begin @(negedge clk); t++; end
        chk("dev_clk_release", {31'd0, ps2_clk}, 32'd1);
        cap[0] = ps2_dat;
        repeat (100) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            if (i > n_edges) return;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            cap[i] = ps2_dat;
            repeat (HALF) @(negedge clk);
        end
        if (n_edges <= 10) return;
        dev_dat_low = ~nack;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done(input int snap, input bit exp_err, input bit wr_on_done, input string tag);
        bit seen;
        int t;
        seen = (done_cnt != snap);
        t = 0;
        while (!seen && t < 5000) begin
            @(negedge clk);
            t++;
            if (o_done === 1'b1) begin
                seen = 1'b1;
                if (wr_on_done) begin
                    i_dat = 8'hA5;
                    i_wr  = 1'b1;
                end
            end
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        @(negedge clk);
        i_wr = 1'b0;
        chk({tag, "_err"}, {31'd0, last_err}, {31'd0, exp_err});
        chk({tag, "_busy_after"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_oe_after"}, {30'd0, o_ps2_clk_oe, o_ps2_dat_oe}, 32'd0);
        if (wr_on_done) begin
            repeat (5) @(negedge clk);
            chk({tag, "_wr_on_done_ignored"}, {30'd0, o_busy, o_ps2_clk_oe}, 32'd0);
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit nack, input bit extra_wr,
                            input bit wr_on_done, input string tag, output logic [10:0] cap);
        int snap;
        snap = done_cnt;
        clear_mon();
        start_wr(d);
        chk({tag, "_busy_rise"}, {31'd0, o_busy}, 32'd1);
        if (extra_wr) begin
            repeat (30) @(negedge clk);
            start_wr(8'h00);
            chk({tag, "_busy_hold"}, {31'd0, o_busy}, 32'd1);
        end
        dev_xfer(11, nack, cap);
        chk({tag, "_frame"}, {21'd0, cap}, {21'd0, frame_of(d)});
        wait_done(snap, nack, wr_on_done, tag);
        chk({tag, "_clk_oe_cycles"}, clk_oe_hi, INH + SETUP);
        chk({tag, "_dat_oe_cycles"}, both_hi, SETUP);
        chk({tag, "_dat_oe_start"}, first_both, INH);
        repeat (100) @(negedge clk);
        chk({tag, "_single_done"}, done_cnt, snap + 1);
    endtask

    initial begin
        logic [10:0] cap;
        logic [10:0] ref_frame;
        logic [7:0]  rb;
        int          snap;

        i_sclr = 1'b1;
        i_wr = 1'b0;
        i_dat = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        i_sclr = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {27'd0, o_ps2_clk_oe, o_ps2_dat_oe, o_busy, o_done, o_err}, 32'd0);

        run_xfer(8'hED, 1'b0, 1'b0, 1'b0, "ed", cap);
        run_xfer(8'hF4, 1'b0, 1'b0, 1'b0, "f4", cap);
        chk("f4_parity", {31'd0, cap[9]}, 32'd0);
        run_xfer(8'h55, 1'b1, 1'b0, 1'b0, "nack55", cap);

        // Reset during SHIFT after the fifth device edge.
        rb = 8'($urandom);
        snap = done_cnt;
        clear_mon();
        start_wr(rb);
        dev_xfer(5, 1'b0, cap);
        ref_frame = frame_of(rb);
        chk("rst_partial_frame", {26'd0, cap[5:0]}, {26'd0, ref_frame[5:0]});
        i_sclr = 1'b1;
        @(negedge clk);
        i_sclr = 1'b0;
        chk("rst_oe", {30'd0, o_ps2_clk_oe, o_ps2_dat_oe}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        repeat (500) @(negedge clk);
        chk("rst_no_done", done_cnt, snap);
        run_xfer(8'hF4, 1'b0, 1'b0, 1'b0, "f4_after_rst", cap);

        run_xfer(8'hED, 1'b0, 1'b1, 1'b0, "ed_extra_wr", cap);

`ifdef KB_TX_TIMEOUT_EN
        begin
            int t;
            rb = 8'($urandom);
            snap = done_cnt;
            clear_mon();
            start_wr(rb);
            dev_xfer(4, 1'b0, cap);
            ref_frame = frame_of(rb);
            chk("to_partial_frame", {27'd0, cap[4:0]}, {27'd0, ref_frame[4:0]});
            t = 0;
            while (o_done !== 1'b1 && t < 25000) begin @(negedge clk); t++; end
            chk("to_done_seen", {31'd0, o_done}, 32'd1);
            chk("to_err", {31'd0, o_err}, 32'd1);
            chk("to_delay", 32'(cyc - rel_time), TO);
            @(negedge clk);
            chk("to_oe_after", {30'd0, o_ps2_clk_oe, o_ps2_dat_oe}, 32'd0);
            chk("to_busy_after", {31'd0, o_busy}, 32'd0);
            chk("to_single_done", done_cnt, snap + 1);
        end
`else
        begin
            bit rn;
            rb = 8'($urandom);
            rn = 1'($urandom_range(0, 1));
            run_xfer(rb, rn, 1'b0, 1'b1, "rand", cap);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keyboard_host_tx.md
Name: keyboard_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard.
- Sits beside the keyboard receive path and drives the PS/2 clock/data lines through open-drain enables.
- Reuses keyboard_negedge_detector to time bit changes on device-generated falling clock edges.
- Checks the device ACK bit and reports completion or error.

Parameters:
- INHIBIT_CYCLES, 6000, clk cycles the clock line is held low before the request (≥100 us at 50 MHz).
- SETUP_CYCLES, 64, clk cycles data and clock are both held low before the clock is released.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed from clock release to ACK completion (20 ms at 50 MHz).
- All parameters must be < 2^20; internal counter is 20 bits.

Ports:
- clk  input  1  system clock (50 MHz)
- i_sclr  input  1  synchronous active-high reset
- i_ps2_clk_n  input  1  raw PS/2 clock line level
- i_ps2_dat_n  input  1  raw PS/2 data line level (2-FF synchronized internally)
- i_wr  input  1  single-cycle start strobe; ignored while o_busy=1
- i_dat  input  8  byte to send; latched on an accepted i_wr
- o_ps2_clk_oe  output  1  1 = pull clock line low, 0 = release
- o_ps2_dat_oe  output  1  1 = pull data line low, 0 = release
- o_busy  output  1  high from accepted i_wr until the o_done cycle inclusive
- o_done  output  1  one-cycle pulse at end of transfer
- o_err  output  1  valid with o_done: 1 = NACK or timeout

Behaviour:
- Reset: one clock with i_sclr=1 puts the block in IDLE. All outputs are 0, counters clear, the shift register clears, and the negedge detector resets.
- Reset mid-transfer: both lines are released on the next edge and no o_done is issued.
- Frame: 11 bits = start(0), D0..D7 LSB first, odd parity (bit = ~^i_dat), stop(1). The device then drives the ACK bit.
- Data drive rule: o_ps2_dat_oe = ~current_bit. The open-drain line is never driven high.
- States:
  - IDLE: oe=00, busy=0. On i_wr: latch {parity, i_dat}, clear counter, go INHIBIT. o_busy rises on the next cycle.
  - INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES cycles, then go REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit) for SETUP_CYCLES cycles. Then release the clock, clear the bit index, clear the timeout counter, go SHIFT.
  - SHIFT: clk_oe=0. On each detected falling edge, index k = 1..9 drives the next bit (D0..D7, then parity). Edge 10 drives the stop bit (dat_oe=0), then go ACK.
  - ACK: on the next falling edge (11th), sample the synchronized data line. 0 = ACK ok, 1 = NACK. Go WAIT_IDLE.
  - WAIT_IDLE: wait until the synchronized clock and data lines are both 1. Then pulse o_done for one cycle (o_err = NACK) and go IDLE.
- Falling edges are recognised only via the sampled detector. Edge pulse latency is ≤ 2 sampling periods (64 clk).
- i_wr while busy: no effect, and the latched data does not change.
- i_wr asserted in the same cycle as o_done: ignored. A new transfer needs i_wr with o_busy=0.

Optional Feature:
- Macro: KB_TX_TIMEOUT_EN.
- With the macro defined: a counter runs from REQ exit through WAIT_IDLE. When it reaches TIMEOUT_CYCLES, both lines are released, o_done=1 and o_err=1 pulse for one cycle, and the block goes to IDLE.
- Without the macro: no timeout counter is instantiated and the block waits indefinitely for device edges. o_err then reflects NACK only.

Test Plan:
- All sims use INHIBIT_CYCLES=200, SETUP_CYCLES=16, TIMEOUT_CYCLES=20000. The device model clocks at 10 us half-period and samples data on rising edges.
- Send 0xED: device captures start 0, bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1, then ACKs. Required: o_done=1, o_err=0, o_busy low the cycle after o_done.
- Send 0xF4: parity captured = 0; clk_oe high for exactly 200+16 cycles after the i_wr edge; dat_oe high for exactly the last 16 of them.
- Device answers the ACK slot with data=1 (NACK) on 0x55: single o_done with o_err=1; both oe=0 afterwards.
- With KB_TX_TIMEOUT_EN defined, device stops clocking after 4 edges: o_done and o_err pulse together 20000 cycles after clock release; lines released.
- i_sclr asserted during SHIFT at edge 5: next cycle oe=00, busy=0, no o_done. A following i_wr with 0xF4 completes normally.
- Second i_wr with 0x00 while busy sending 0xED: device still receives 0xED, and exactly one o_done is produced.
